in_debounce: RTL and testbench
==============================

Name: in_debounce

Overview:
- Conditions the raw asynchronous `in` level before it reaches the control FSM that consumes `in`.
  - Synchronises the level.
  - Qualifies it with a stable-cycle filter.
  - Emits a clean level plus one-cycle edge pulses.
- Aborted transitions (glitches) are counted for debug.
- Sits directly upstream of the state-machine block.
- Its clean_out drives that block's `in` input, in the same clk domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on raw_in; legal range >= 2.
- STABLE_CYCLES, 4, consecutive synchronised cycles required to accept a new level; legal range >= 1.
- CNT_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- raw_in  input  1  unsynchronised input level.
- enable  input  1  filter enable; when low, no new level is accepted.
- clear_cnt  input  1  synchronous clear of glitch_cnt.
- clean_out  output  1  debounced level; feeds the downstream FSM `in`.
- rise  output  1  one-cycle pulse, coincident with clean_out going 0->1.
- fall  output  1  one-cycle pulse, coincident with clean_out going 1->0.
- glitch_cnt  output  CNT_W  saturating count of aborted transitions.
- state_o  output  2  current filter state, for debug.

Behaviour:
- Reset: clk and reset are decided as above (reset asynchronous, active-high; clock clk). Reset clears all of the following to 0:
  - sync flops
  - state (LOW)
  - stable counter
  - clean_out, rise, fall
  - glitch_cnt
- Reset asserted mid-operation aborts any wait immediately, with no pulse and no glitch increment.
- Synchroniser: raw_in passes through a chain of SYNC_STAGES flops; `s` denotes the last stage. All filtering uses `s` only.
- States (2-bit encoding): LOW=0, RISE_WAIT=1, HIGH=2, FALL_WAIT=3.
- LOW: if enable and s=1 -> RISE_WAIT, cnt<=1.
- RISE_WAIT:
  - If !enable -> LOW, cnt<=0, no glitch count.
  - Else if s=0 -> LOW, glitch_cnt++.
  - Else if cnt==STABLE_CYCLES -> HIGH, clean_out<=1, rise<=1.
  - Else cnt++.
- HIGH: if enable and s=0 -> FALL_WAIT, cnt<=1.
- FALL_WAIT: mirror of RISE_WAIT.
  - !enable -> HIGH.
  - s=1 -> HIGH, glitch_cnt++.
  - cnt==STABLE_CYCLES -> LOW, clean_out<=0, fall<=1.
- clean_out changes only on the LOW<->HIGH acceptance transitions; it is constant in wait states.
- rise/fall are registered, high for exactly one cycle, never both high together.
- Latency: raw_in held at a new level -> clean_out changes exactly SYNC_STAGES+STABLE_CYCLES+1 rising edges after the first edge sampling it. Default: 7 cycles.
- Counter width: clog2(STABLE_CYCLES+1). The counter never exceeds STABLE_CYCLES.
- glitch_cnt saturates at 2^CNT_W-1; further aborts leave it unchanged.
- clear_cnt and a glitch in the same cycle: clear wins, glitch_cnt=0.
- enable low: the synchroniser keeps running. Leaving a wait state because of !enable is not a glitch.
- Re-enable while s differs from clean_out: the wait starts on the next edge, with full latency.

Decomposition:
- Shared package in_cond_pkg holds:
  - typedef enum logic [1:0] deb_state_t {DEB_LOW, DEB_RISE_WAIT, DEB_HIGH, DEB_FALL_WAIT}
  - localparam defaults for SYNC_STAGES and STABLE_CYCLES
- One sub-module: sync_chain, a parameterised N-flop synchroniser with asynchronous reset. It is reused wherever asynchronous inputs enter.

Test Plan:
- Reset then raw_in=1 held (defaults) -> clean_out=1 and rise=1 on edge 7, rise=0 on edge 8; glitch_cnt=0, state_o=2.
- From HIGH, raw_in=0 held -> fall pulses 1 cycle on edge 7, clean_out=0, state_o=0.
- From LOW, raw_in high 3 cycles then low -> clean_out stays 0, glitch_cnt=1, state_o returns to 0.
- 300 three-cycle pulses with CNT_W=8 -> glitch_cnt saturates at 255. Then clear_cnt coincident with one more glitch -> glitch_cnt=0.
- RISE_WAIT reached, enable dropped -> state_o=0 next edge, glitch_cnt unchanged. Re-enable with raw_in=1 -> clean_out rises STABLE_CYCLES+1 edges after the enable edge.
- Reset asserted asynchronously between edges during FALL_WAIT -> all outputs 0 immediately, no fall pulse, glitch_cnt=0.

Source files
------------

// File: rtl/in_cond_pkg.sv
// Shared types and defaults for the input-conditioning blocks.
// Holds the debounce filter state encoding and parameter defaults.
package in_cond_pkg;

  typedef enum logic [1:0] {
    DEB_LOW       = 2'd0,
    DEB_RISE_WAIT = 2'd1,
    DEB_HIGH      = 2'd2,
    DEB_FALL_WAIT = 2'd3
  } deb_state_t;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/in_debounce_if.sv
// Signal bundle between the debounce filter and its environment.
// The master drives the raw level and controls; the slave returns the conditioned outputs.
interface in_debounce_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             raw_in;
  logic             enable;
  logic             clear_cnt;
  logic             clean_out;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] glitch_cnt;
  logic [1:0]       state_o;

  modport master (
    output raw_in,
    output enable,
    output clear_cnt,
    input  clean_out,
    input  rise,
    input  fall,
    input  glitch_cnt,
    input  state_o
  );

  modport slave (
    input  raw_in,
    input  enable,
    input  clear_cnt,
    output clean_out,
    output rise,
    output fall,
    output glitch_cnt,
    output state_o
  );

endinterface

// File: rtl/sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit level.
// Asynchronous active-high reset clears every stage.
module sync_chain #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/in_debounce.sv
// Debounce filter: synchronises raw_in, requires STABLE_CYCLES stable samples to accept a
// new level, emits clean level plus one-cycle edge pulses and counts aborted transitions.
module in_debounce
  import in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic         clk,
  input  logic         reset,
  in_debounce_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] StableMax = CntW'(STABLE_CYCLES);

  logic             w_s;
  logic             w_at_max;
  logic             w_glitch;
  deb_state_t       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_clean, w_clean_d;
  logic             r_rise, w_rise_d;
  logic             r_fall, w_fall_d;
  logic [CNT_W-1:0] r_glitch_cnt, w_glitch_cnt_d;

  sync_chain #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (bus.raw_in),
    .o_q  (w_s)
  );

  assign w_at_max = (r_cnt == StableMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DEB_LOW;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      DEB_LOW: begin
        if (bus.enable && w_s) w_state_d = DEB_RISE_WAIT;
      end
      DEB_RISE_WAIT: begin
        if (!bus.enable || !w_s) w_state_d = DEB_LOW;
        else if (w_at_max)       w_state_d = DEB_HIGH;
      end
      DEB_HIGH: begin
        if (bus.enable && !w_s) w_state_d = DEB_FALL_WAIT;
      end
      DEB_FALL_WAIT: begin
        if (!bus.enable || w_s) w_state_d = DEB_HIGH;
        else if (w_at_max)      w_state_d = DEB_LOW;
      end
    endcase
  end

  // Next values of the registered outputs; the stable counter restarts at 1 on entering a wait.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_clean_d = r_clean;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    w_glitch  = 1'b0;
    unique case (r_state)
      DEB_LOW: begin
        if (bus.enable && w_s) w_cnt_d = CntW'(1);
      end
      DEB_RISE_WAIT: begin
        if (!bus.enable) begin
          w_cnt_d = '0;
        end else if (!w_s) begin
          w_cnt_d  = '0;
          w_glitch = 1'b1;
        end else if (w_at_max) begin
          w_cnt_d   = '0;
          w_clean_d = 1'b1;
          w_rise_d  = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      DEB_HIGH: begin
        if (bus.enable && !w_s) w_cnt_d = CntW'(1);
      end
      DEB_FALL_WAIT: begin
        if (!bus.enable) begin
          w_cnt_d = '0;
        end else if (w_s) begin
          w_cnt_d  = '0;
          w_glitch = 1'b1;
        end else if (w_at_max) begin
          w_cnt_d   = '0;
          w_clean_d = 1'b0;
          w_fall_d  = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
    endcase
  end

  // Clear takes priority over a coincident glitch; the count saturates at all-ones.
  always_comb begin
    w_glitch_cnt_d = r_glitch_cnt;
    if (bus.clear_cnt) begin
      w_glitch_cnt_d = '0;
    end else if (w_glitch && (r_glitch_cnt != {CNT_W{1'b1}})) begin
      w_glitch_cnt_d = r_glitch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_clean      <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_clean      <= w_clean_d;
      r_rise       <= w_rise_d;
      r_fall       <= w_fall_d;
      r_glitch_cnt <= w_glitch_cnt_d;
    end
  end

  assign bus.clean_out  = r_clean;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.glitch_cnt = r_glitch_cnt;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce at default parameters.
// Expected values are hand-derived edge counts from the moment raw_in or enable changes.
module tb_in_debounce;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  in_debounce_if #(.CNT_W(8)) bus ();

  in_debounce #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.raw_in    = 1'b0;
    bus.enable    = 1'b1;
    bus.clear_cnt = 1'b0;
    step(3);
    check_eq("rst_clean", 32'(bus.clean_out), 0);
    check_eq("rst_rise", 32'(bus.rise), 0);
    check_eq("rst_fall", 32'(bus.fall), 0);
    check_eq("rst_glitch", 32'(bus.glitch_cnt), 0);
    check_eq("rst_state", 32'(bus.state_o), 0);
    reset = 1'b0;

    // Rising acceptance: edge 7 after raw_in goes high.
    bus.raw_in = 1'b1;
    step(6);
    check_eq("rise_e6_clean", 32'(bus.clean_out), 0);
    check_eq("rise_e6_state", 32'(bus.state_o), 1);
    step(1);
    check_eq("rise_e7_clean", 32'(bus.clean_out), 1);
    check_eq("rise_e7_rise", 32'(bus.rise), 1);
    check_eq("rise_e7_state", 32'(bus.state_o), 2);
    check_eq("rise_e7_glitch", 32'(bus.glitch_cnt), 0);
    step(1);
    check_eq("rise_e8_rise", 32'(bus.rise), 0);
    check_eq("rise_e8_clean", 32'(bus.clean_out), 1);

    // Falling acceptance.
    bus.raw_in = 1'b0;
    step(6);
    check_eq("fall_e6_clean", 32'(bus.clean_out), 1);
    check_eq("fall_e6_state", 32'(bus.state_o), 3);
    check_eq("fall_e6_fall", 32'(bus.fall), 0);
    step(1);
    check_eq("fall_e7_fall", 32'(bus.fall), 1);
    check_eq("fall_e7_rise", 32'(bus.rise), 0);
    check_eq("fall_e7_clean", 32'(bus.clean_out), 0);
    check_eq("fall_e7_state", 32'(bus.state_o), 0);
    step(1);
    check_eq("fall_e8_fall", 32'(bus.fall), 0);

    // Three-cycle pulse aborts the rise wait.
    bus.raw_in = 1'b1;
    step(3);
    bus.raw_in = 1'b0;
    step(2);
    check_eq("gl_wait_state", 32'(bus.state_o), 1);
    step(1);
    check_eq("gl_state", 32'(bus.state_o), 0);
    check_eq("gl_cnt", 32'(bus.glitch_cnt), 1);
    check_eq("gl_clean", 32'(bus.clean_out), 0);
    step(4);
    check_eq("gl_no_rise", 32'(bus.rise), 0);

    // Dropping enable in RISE_WAIT is not a glitch; re-enable restarts the full wait.
    bus.raw_in = 1'b1;
    step(3);
    check_eq("en_wait_state", 32'(bus.state_o), 1);
    bus.enable = 1'b0;
    step(1);
    check_eq("en_off_state", 32'(bus.state_o), 0);
    check_eq("en_off_glitch", 32'(bus.glitch_cnt), 1);
    step(3);
    check_eq("en_off_hold", 32'(bus.state_o), 0);
    bus.enable = 1'b1;
    step(4);
    check_eq("en_e4_clean", 32'(bus.clean_out), 0);
    check_eq("en_e4_state", 32'(bus.state_o), 1);
    step(1);
    check_eq("en_e5_clean", 32'(bus.clean_out), 1);
    check_eq("en_e5_rise", 32'(bus.rise), 1);

    // Asynchronous reset between edges during FALL_WAIT.
    bus.raw_in = 1'b0;
    step(3);
    check_eq("ar_wait_state", 32'(bus.state_o), 3);
    #3;
    reset = 1'b1;
    #1;
    check_eq("ar_clean", 32'(bus.clean_out), 0);
    check_eq("ar_state", 32'(bus.state_o), 0);
    check_eq("ar_glitch", 32'(bus.glitch_cnt), 0);
    check_eq("ar_fall", 32'(bus.fall), 0);
    check_eq("ar_rise", 32'(bus.rise), 0);
    step(8);
    check_eq("ar_hold_fall", 32'(bus.fall), 0);
    reset = 1'b0;
    step(8);
    check_eq("ar_post_state", 32'(bus.state_o), 0);
    check_eq("ar_post_fall", 32'(bus.fall), 0);
    check_eq("ar_post_clean", 32'(bus.clean_out), 0);

    // 300 glitches saturate an 8-bit counter.
    for (int i = 0; i < 300; i++) begin
      bus.raw_in = 1'b1;
      step(3);
      bus.raw_in = 1'b0;
      step(5);
    end
    check_eq("sat_cnt", 32'(bus.glitch_cnt), 255);
    check_eq("sat_state", 32'(bus.state_o), 0);

    // clear_cnt on the very edge that registers another glitch.
    bus.raw_in = 1'b1;
    step(3);
    bus.raw_in = 1'b0;
    step(2);
    check_eq("clr_pre_cnt", 32'(bus.glitch_cnt), 255);
    check_eq("clr_pre_state", 32'(bus.state_o), 1);
    bus.clear_cnt = 1'b1;
    step(1);
    bus.clear_cnt = 1'b0;
    check_eq("clr_cnt", 32'(bus.glitch_cnt), 0);
    check_eq("clr_state", 32'(bus.state_o), 0);

    // Counting resumes after a clear.
    step(2);
    bus.raw_in = 1'b1;
    step(3);
    bus.raw_in = 1'b0;
    step(5);
    check_eq("resume_cnt", 32'(bus.glitch_cnt), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
